axi4_r_buffer: RTL and testbench

Elastic buffer for the AXI4 read data (R) channel. It is the return-path counterpart of the W-channel buffer and sits between a downstream slave port's R channel (push side) and the upstream master-facing R channel (pop side). It decouples rready back-pressure with a self-contained circular FIFO. It also exports fill and completed-burst status, which the bridge uses to throttle AR issue.

---
 rtl/axi4_r_buffer.sv | 107 ++++++++++
 tb/tb_axi4_r_buffer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_r_buffer.sv
// axi4_r_buffer
//   Elastic FIFO for the AXI4 read-data (R) channel. Beats arrive from a
//   downstream slave port (m_axi4_*) and are replayed in order to the
//   upstream master-facing port (s_axi4_*). Occupancy and the number of
//   stored burst-terminating beats are exported so the bridge can throttle
//   AR issue.
//
// Ports
//   axi4_aclk / axi4_arstn   clock, async active-low reset
//   m_axi4_r*                push side (rid, rdata, rresp, rlast, ruser, rvalid in; rready out)
//   s_axi4_r*                pop side  (payload, rvalid out; rready in)
//   fill_level               occupied entries, 0..BUFFER_DEPTH
//   bursts_buffered          stored entries with rlast=1
module axi4_r_buffer #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_USER_WIDTH = 4,
  parameter int BUFFER_DEPTH   = 4,
  localparam int PW            = $clog2(BUFFER_DEPTH) + 1
) (
  input  logic                      axi4_aclk,
  input  logic                      axi4_arstn,
  input  logic [AXI_ID_WIDTH-1:0]   m_axi4_rid,
  input  logic [AXI_DATA_WIDTH-1:0] m_axi4_rdata,
  input  logic [1:0]                m_axi4_rresp,
  input  logic                      m_axi4_rlast,
  input  logic [AXI_USER_WIDTH-1:0] m_axi4_ruser,
  input  logic                      m_axi4_rvalid,
  output logic                      m_axi4_rready,
  output logic [AXI_ID_WIDTH-1:0]   s_axi4_rid,
  output logic [AXI_DATA_WIDTH-1:0] s_axi4_rdata,
  output logic [1:0]                s_axi4_rresp,
  output logic                      s_axi4_rlast,
  output logic [AXI_USER_WIDTH-1:0] s_axi4_ruser,
  output logic                      s_axi4_rvalid,
  input  logic                      s_axi4_rready,
  output logic [PW-1:0]             fill_level,
  output logic [PW-1:0]             bursts_buffered
);

  localparam int AW = PW - 1;
  localparam int EW = AXI_USER_WIDTH + AXI_ID_WIDTH + 2 + AXI_DATA_WIDTH + 1;

  logic [EW-1:0] mem_q [BUFFER_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] fill_q, fill_d;
  logic [PW-1:0] bursts_q, bursts_d;

  logic empty, full, push, pop;
  logic last_in, last_out;

  // The extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);

  // Both handshakes depend only on registered state on the buffer's side,
  // so no combinational path exists from s_axi4_rready to m_axi4_rready.
  assign m_axi4_rready = !full;
  assign s_axi4_rvalid = !empty;
  assign push          = m_axi4_rvalid && !full;
  assign pop           = !empty && s_axi4_rready;

  assign {s_axi4_ruser, s_axi4_rid, s_axi4_rresp, s_axi4_rdata, s_axi4_rlast} =
    mem_q[rptr_q[AW-1:0]];

  assign last_in  = push && m_axi4_rlast;
  assign last_out = pop && s_axi4_rlast;

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    fill_d   = fill_q;
    bursts_d = bursts_q;
    if (push) wptr_d = wptr_q + PW'(1);
    if (pop)  rptr_d = rptr_q + PW'(1);
    if (push && !pop)      fill_d = fill_q + PW'(1);
    else if (pop && !push) fill_d = fill_q - PW'(1);
    if (last_in && !last_out)      bursts_d = bursts_q + PW'(1);
    else if (last_out && !last_in) bursts_d = bursts_q - PW'(1);
  end

  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      fill_q   <= '0;
      bursts_q <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      fill_q   <= fill_d;
      bursts_q <= bursts_d;
    end
  end

  // Storage is deliberately left unreset; payload is only meaningful while rvalid=1.
  always_ff @(posedge axi4_aclk) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= {m_axi4_ruser, m_axi4_rid, m_axi4_rresp, m_axi4_rdata, m_axi4_rlast};
    end
  end

  assign fill_level      = fill_q;
  assign bursts_buffered = bursts_q;

endmodule

// File: tb/tb_axi4_r_buffer.sv
module tb_axi4_r_buffer;

  localparam int DEPTH = 4;
  localparam int PW    = 3;

  typedef struct packed {
    logic [3:0]  user;
    logic [3:0]  id;
    logic [1:0]  resp;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic          clk = 0;
  logic          arstn = 0;
  beat_t         drv = '0;
  logic          m_rvalid = 0;
  logic          m_rready;
  logic [3:0]    s_rid;
  logic [31:0]   s_rdata;
  logic [1:0]    s_rresp;
  logic          s_rlast;
  logic [3:0]    s_ruser;
  logic          s_rvalid;
  logic          s_rready = 0;
  logic [PW-1:0] fill;
  logic [PW-1:0] bursts;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi4_r_buffer #(
    .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(4), .BUFFER_DEPTH(DEPTH)
  ) dut (
    .axi4_aclk(clk),            .axi4_arstn(arstn),
    .m_axi4_rid(drv.id),        .m_axi4_rdata(drv.data),   .m_axi4_rresp(drv.resp),
    .m_axi4_rlast(drv.last),    .m_axi4_ruser(drv.user),   .m_axi4_rvalid(m_rvalid),
    .m_axi4_rready(m_rready),
    .s_axi4_rid(s_rid),         .s_axi4_rdata(s_rdata),    .s_axi4_rresp(s_rresp),
    .s_axi4_rlast(s_rlast),     .s_axi4_ruser(s_ruser),    .s_axi4_rvalid(s_rvalid),
    .s_axi4_rready(s_rready),
    .fill_level(fill),          .bursts_buffered(bursts)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the buffer is an ordered list of at most DEPTH beats.
  beat_t mq[$];
  logic [31:0] out_q[$];
  logic accepted = 0;
  int sz, nl;
  beat_t got;

  always @(negedge clk) begin
    if (arstn === 1'b1) begin
      sz = mq.size();
      nl = 0;
      foreach (mq[i]) if (mq[i].last) nl++;
      chk("rvalid", 64'(s_rvalid), 64'(sz > 0));
      chk("rready", 64'(m_rready), 64'(sz < DEPTH));
      chk("fill_level", 64'(fill), 64'(sz));
      chk("bursts_buffered", 64'(bursts), 64'(nl));
      if (s_rvalid && s_rready) begin
        got = {s_ruser, s_rid, s_rresp, s_rdata, s_rlast};
        if (sz == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h expected none at %0t", got, $time);
        end else begin
          chk("payload", 64'(got), 64'(mq[0]));
          out_q.push_back(s_rdata);
          void'(mq.pop_front());
        end
      end
      accepted = 0;
      if (m_rvalid && sz < DEPTH) begin
        mq.push_back(drv);
        accepted = 1;
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic beat_t mk(input logic [31:0] d, input logic l);
    beat_t b;
    b.user = 4'($urandom);
    b.id   = 4'($urandom);
    b.resp = 2'($urandom);
    b.data = d;
    b.last = l;
    return b;
  endfunction

  task automatic push_beat(input beat_t b, input int budget);
    int n = 0;
    drv = b;
    m_rvalid = 1;
    do begin
      cycle();
      n++;
    end while (!accepted && n < budget);
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got no accept expected accept of %0h", b.data);
    end
    m_rvalid = 0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    s_rready = 1;
    while (mq.size() > 0 && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_done", 64'(mq.size()), 64'd0);
    s_rready = 0;
  endtask

  logic stream_done;
  beat_t b;

  initial begin
    // Reset values
    repeat (2) cycle();
    chk("rst_rvalid", 64'(s_rvalid), 64'd0);
    chk("rst_rready", 64'(m_rready), 64'd1);
    chk("rst_fill", 64'(fill), 64'd0);
    chk("rst_bursts", 64'(bursts), 64'd0);
    arstn = 1;
    cycle();

    // Single beat, one-cycle latency
    b = '{user: 4'h5, id: 4'h3, resp: 2'h0, data: 32'hDEADBEEF, last: 1'b1};
    push_beat(b, 4);
    chk("single_rvalid", 64'(s_rvalid), 64'd1);
    chk("single_data", 64'(s_rdata), 64'hDEADBEEF);
    chk("single_rid", 64'(s_rid), 64'd3);
    chk("single_fill", 64'(fill), 64'd1);
    chk("single_bursts", 64'(bursts), 64'd1);
    s_rready = 1;
    cycle();
    s_rready = 0;
    chk("single_pop_fill", 64'(fill), 64'd0);
    chk("single_pop_bursts", 64'(bursts), 64'd0);

    // Fill to full, 5th beat held, then pop while full
    out_q.delete();
    for (int i = 1; i <= 4; i++) push_beat(mk(32'(i), 1'b0), 4);
    chk("full_rready", 64'(m_rready), 64'd0);
    chk("full_fill", 64'(fill), 64'd4);
    drv = mk(32'd5, 1'b1);
    m_rvalid = 1;
    repeat (3) cycle();
    chk("full_hold_fill", 64'(fill), 64'd4);
    s_rready = 1;
    cycle();
    chk("full_pop_no_push", 64'(fill), 64'd3);
    chk("full_pop_rready", 64'(m_rready), 64'd1);
    cycle();
    chk("push_pop_fill", 64'(fill), 64'd3);
    m_rvalid = 0;
    drain(10);
    chk("order_cnt", 64'(out_q.size()), 64'd5);
    for (int i = 0; i < 5 && i < out_q.size(); i++)
      chk("order_data", 64'(out_q[i]), 64'(i + 1));

    // Wrap-around stream with random valid/ready
    out_q.delete();
    stream_done = 0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          repeat ($urandom_range(0, 2)) cycle();
          push_beat(mk(32'(i), 1'($urandom_range(0, 1))), 40);
        end
        stream_done = 1;
      end
      begin
        while (!stream_done) begin
          s_rready = 1'($urandom_range(0, 1));
          cycle();
        end
      end
    join
    drain(20);
    chk("stream_cnt", 64'(out_q.size()), 64'd20);
    for (int i = 0; i < 20 && i < out_q.size(); i++)
      chk("stream_data", 64'(out_q[i]), 64'(i));

    // Burst counting
    push_beat(mk(32'h100, 1'b0), 4);
    push_beat(mk(32'h101, 1'b0), 4);
    push_beat(mk(32'h102, 1'b1), 4);
    push_beat(mk(32'h200, 1'b1), 4);
    chk("bursts_two", 64'(bursts), 64'd2);
    s_rready = 1;
    repeat (3) cycle();
    s_rready = 0;
    chk("bursts_one", 64'(bursts), 64'd1);
    s_rready = 1;
    cycle();
    s_rready = 0;
    chk("bursts_zero", 64'(bursts), 64'd0);

    // Async reset with 3 entries stored
    for (int i = 0; i < 3; i++) push_beat(mk(32'h300 + 32'(i), 1'b1), 4);
    chk("pre_rst_fill", 64'(fill), 64'd3);
    #1 arstn = 0;
    #1;
    chk("arst_rvalid", 64'(s_rvalid), 64'd0);
    chk("arst_rready", 64'(m_rready), 64'd1);
    chk("arst_fill", 64'(fill), 64'd0);
    chk("arst_bursts", 64'(bursts), 64'd0);
    mq.delete();
    arstn = 1;
    cycle();
    push_beat(mk(32'hA5A5_0001, 1'b1), 4);
    chk("post_rst_data", 64'(s_rdata), 64'hA5A5_0001);
    chk("post_rst_fill", 64'(fill), 64'd1);
    drain(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
